des_key_sched_seq: RTL and testbench

- Sequential, parametrised DES/3DES round-key generator for the cipher datapath.
- Accepts one 64-bit key, or three for 3DES, through a valid/ready handshake.
- Streams 48-bit subkeys one per accepted beat, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Replaces the flat 16-output combinational schedule: one PC1/PC2 instance, with rotation applied in place on registered C/D halves.

---
 rtl/des_key_sched_seq_if.sv | 32 +++
 rtl/des_key_sched_seq.sv | 187 ++++++++++++++++++
 tb/tb_des_key_sched_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/des_key_sched_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// des_key_sched_seq_if : key-load and subkey-stream handshake bundle. Rev 1.0
// ---------------------------------------------------------------------------
interface des_key_sched_seq_if #(
  parameter int KEY_COUNT = 1,
  parameter int KIDX_W    = 2
) ();
  logic                    key_valid;
  logic                    key_ready;
  logic [64*KEY_COUNT-1:0] key_in;
  logic                    mode_dec;
  logic                    abort;
  logic                    rk_valid;
  logic                    rk_ready;
  logic [47:0]             rk_data;
  logic [3:0]              rk_round;
  logic [KIDX_W-1:0]       rk_key_idx;
  logic                    rk_last;
  logic                    busy;

  modport master (
    output key_valid, key_in, mode_dec, abort, rk_ready,
    input  key_ready, rk_valid, rk_data, rk_round, rk_key_idx, rk_last, busy
  );

  modport slave (
    input  key_valid, key_in, mode_dec, abort, rk_ready,
    output key_ready, rk_valid, rk_data, rk_round, rk_key_idx, rk_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/des_key_sched_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// des_key_sched_seq : sequential DES/3DES subkey streamer, one PC1/PC2. Rev 1.0
// ---------------------------------------------------------------------------
module des_key_sched_seq #(
  parameter int KEY_COUNT = 1,
  parameter int KIDX_W    = 2
) (
  input wire logic          clk,
  input wire logic          rst,
  des_key_sched_seq_if.slave bus
);

  generate
    if (KEY_COUNT != 1 && KEY_COUNT != 3) begin : g_bad_key_count
      $error("des_key_sched_seq: KEY_COUNT must be 1 or 3");
    end
  endgenerate

  localparam int PC1_TAB [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Bit n set means subkey K(n+1) uses a 2-position shift, clear means 1.
  localparam logic [15:0] SHIFT2 = 16'b0111_1110_1111_1100;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [55:0] f_pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    return r;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return r;
  endfunction

  function automatic logic [27:0] f_rl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] f_rr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic [55:0] f_rotl(input logic [55:0] cd, input logic two);
    return {f_rl28(cd[55:28], two), f_rl28(cd[27:0], two)};
  endfunction

  function automatic logic [55:0] f_rotr(input logic [55:0] cd, input logic two);
    return {f_rr28(cd[55:28], two), f_rr28(cd[27:0], two)};
  endfunction

  // 3DES EDE order: encrypt walks keys 0,1,2; decrypt walks 2,1,0.
  function automatic logic [1:0] f_kidx(input logic [1:0] step, input logic dec);
    if (KEY_COUNT == 1) return 2'd0;
    return dec ? (2'd2 - step) : step;
  endfunction

  // Middle key of an EDE triple runs opposite to the selected mode.
  function automatic logic f_dir(input logic [1:0] step, input logic dec);
    if (KEY_COUNT == 1) return dec;
    return dec ? (step != 2'd1) : (step == 2'd1);
  endfunction

  function automatic logic [63:0] f_sel_key(input logic [64*KEY_COUNT-1:0] keys,
                                            input logic [1:0] idx);
    logic [63:0] r;
    r = keys[63:0];
    for (int k = 0; k < KEY_COUNT; k++) if (idx == 2'(k)) r = keys[64*k +: 64];
    return r;
  endfunction

  // Decrypt starts from the unrotated C0/D0, which already yields K16.
  function automatic logic [55:0] f_load(input logic [63:0] key, input logic dec);
    logic [55:0] p;
    p = f_pc1(key);
    return dec ? p : f_rotl(p, 1'b0);
  endfunction

  state_t                  state_q, state_d;
  logic [64*KEY_COUNT-1:0] key_q, key_d;
  logic                    mode_q, mode_d;
  logic [3:0]              beat_q, beat_d;
  logic [1:0]              step_q, step_d;
  logic [55:0]             cd_q, cd_d;

  logic       run;
  logic       cur_dir;
  logic [1:0] cur_idx;
  logic       last_step;
  logic [3:0] beat_nxt;
  logic [1:0] step_nxt;

  always_comb begin
    run       = (state_q == ST_RUN);
    cur_dir   = f_dir(step_q, mode_q);
    cur_idx   = f_kidx(step_q, mode_q);
    last_step = (step_q == 2'(KEY_COUNT - 1));
    beat_nxt  = beat_q + 4'd1;
    step_nxt  = step_q + 2'd1;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    mode_d  = mode_q;
    beat_d  = beat_q;
    step_d  = step_q;
    cd_d    = cd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.key_valid) begin
          key_d   = bus.key_in;
          mode_d  = bus.mode_dec;
          beat_d  = 4'd0;
          step_d  = 2'd0;
          cd_d    = f_load(f_sel_key(bus.key_in, f_kidx(2'd0, bus.mode_dec)),
                           f_dir(2'd0, bus.mode_dec));
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.rk_ready) begin
          if (beat_q == 4'd15) begin
            if (last_step) begin
              state_d = ST_IDLE;
            end else begin
              step_d = step_nxt;
              beat_d = 4'd0;
              cd_d   = f_load(f_sel_key(key_q, f_kidx(step_nxt, mode_q)),
                              f_dir(step_nxt, mode_q));
            end
          end else begin
            beat_d = beat_nxt;
            // Undo the shift of the subkey just emitted when walking K16..K1.
            cd_d   = cur_dir ? f_rotr(cd_q, SHIFT2[4'(5'd16 - {1'b0, beat_nxt})])
                             : f_rotl(cd_q, SHIFT2[beat_nxt]);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      mode_q  <= 1'b0;
      beat_q  <= 4'd0;
      step_q  <= 2'd0;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      beat_q  <= beat_d;
      step_q  <= step_d;
      cd_q    <= cd_d;
    end
  end

  assign bus.key_ready  = !run;
  assign bus.busy       = run;
  assign bus.rk_valid   = run;
  assign bus.rk_data    = run ? f_pc2(cd_q) : 48'd0;
  assign bus.rk_round   = run ? (cur_dir ? (4'd15 - beat_q) : beat_q) : 4'd0;
  assign bus.rk_key_idx = run ? KIDX_W'(cur_idx) : '0;
  assign bus.rk_last    = run && last_step && (beat_q == 4'd15);

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_des_key_sched_seq : directed self-checking bench for des_key_sched_seq. Rev 1.0
// ---------------------------------------------------------------------------
module tb_des_key_sched_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  des_key_sched_seq_if #(.KEY_COUNT(1), .KIDX_W(2)) bus1 ();
  des_key_sched_seq_if #(.KEY_COUNT(3), .KIDX_W(2)) bus3 ();

  des_key_sched_seq #(.KEY_COUNT(1), .KIDX_W(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  des_key_sched_seq #(.KEY_COUNT(3), .KIDX_W(2)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

  // Published subkeys K1..K16 for KEY_A.
  localparam logic [47:0] K_TAB [0:15] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  localparam logic [63:0] K3_TAB [0:2] = '{
    64'h0123456789ABCDEF, 64'h23456789ABCDEF01, 64'h456789ABCDEF0123};

  localparam int R_PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int R_PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Reference subkey Kn built from C0/D0 by the cumulative left shift.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int n);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] r;
    int tot;
    for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - R_PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    tot = 0;
    for (int k = 1; k <= n; k++) tot += (k == 1 || k == 2 || k == 9 || k == 16) ? 1 : 2;
    for (int s = 0; s < tot; s++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[47 - i] = cd[56 - R_PC2[i]];
    return r;
  endfunction

  task automatic test_reset;
    checks++;
    if (bus1.key_ready !== 1'b1 || bus1.rk_valid !== 1'b0 || bus1.busy !== 1'b0)
      begin errors++; $display("FAIL reset_ctl1: ready=%b valid=%b busy=%b, need 1 0 0",
                               bus1.key_ready, bus1.rk_valid, bus1.busy); end
    checks++;
    if (bus1.rk_data !== 48'd0 || bus1.rk_round !== 4'd0 || bus1.rk_key_idx !== 2'd0 ||
        bus1.rk_last !== 1'b0)
      begin errors++; $display("FAIL reset_rk1: data=%h round=%0d idx=%0d last=%b, need zeros",
                               bus1.rk_data, bus1.rk_round, bus1.rk_key_idx, bus1.rk_last); end
    checks++;
    if (bus3.key_ready !== 1'b1 || bus3.rk_valid !== 1'b0 || bus3.busy !== 1'b0 ||
        bus3.rk_data !== 48'd0 || bus3.rk_last !== 1'b0)
      begin errors++; $display("FAIL reset_3: ready=%b valid=%b busy=%b data=%h, need 1 0 0 0",
                               bus3.key_ready, bus3.rk_valid, bus3.busy, bus3.rk_data); end
  endtask

  // Full-rate encrypt with a competing key_valid held during the run.
  task automatic test_encrypt;
    bus1.key_in = KEY_A; bus1.mode_dec = 1'b0; bus1.key_valid = 1'b1; bus1.rk_ready = 1'b1;
    checks++;
    if (bus1.key_ready !== 1'b1)
      begin errors++; $display("FAIL enc_ready: key_ready=%b need 1", bus1.key_ready); end
    @(posedge clk); #1;
    bus1.key_in = KEY_B; bus1.mode_dec = 1'b1;
    for (int b = 0; b < 16; b++) begin
      checks++;
      if (bus1.rk_valid !== 1'b1 || bus1.busy !== 1'b1 || bus1.key_ready !== 1'b0 ||
          bus1.rk_data !== K_TAB[b] || bus1.rk_round !== 4'(b) ||
          bus1.rk_key_idx !== 2'd0 || bus1.rk_last !== (b == 15))
        begin errors++; $display("FAIL enc_beat%0d: v=%b data=%h round=%0d last=%b, need 1 %h %0d %b",
                                 b, bus1.rk_valid, bus1.rk_data, bus1.rk_round, bus1.rk_last,
                                 K_TAB[b], b, (b == 15)); end
      @(posedge clk); #1;
    end
    bus1.key_valid = 1'b0;
    checks++;
    if (bus1.key_ready !== 1'b1 || bus1.rk_valid !== 1'b0 || bus1.busy !== 1'b0)
      begin errors++; $display("FAIL enc_done: ready=%b valid=%b busy=%b, need 1 0 0",
                               bus1.key_ready, bus1.rk_valid, bus1.busy); end
  endtask

  // One DES stream with rk_ready dropped stall_pct percent of the time.
  task automatic test_stream(input logic dec, input int stall_pct);
    int n, cyc;
    logic held;
    logic [47:0] h_data;
    logic [3:0] h_round;
    logic h_last;
    logic [47:0] exp_data;
    int exp_round;
    bus1.key_in = KEY_A; bus1.mode_dec = dec; bus1.key_valid = 1'b1; bus1.rk_ready = 1'b0;
    @(posedge clk); #1;
    bus1.key_valid = 1'b0;
    n = 0; cyc = 0; held = 1'b0; h_data = '0; h_round = '0; h_last = 1'b0;
    while (n < 16 && cyc < 400) begin
      if (held) begin
        checks++;
        if (bus1.rk_valid !== 1'b1 || bus1.rk_data !== h_data || bus1.rk_round !== h_round ||
            bus1.rk_last !== h_last)
          begin errors++; $display("FAIL stall_hold n=%0d: v=%b data=%h round=%0d, need 1 %h %0d",
                                   n, bus1.rk_valid, bus1.rk_data, bus1.rk_round, h_data, h_round); end
      end
      exp_round = dec ? 15 - n : n;
      exp_data  = K_TAB[exp_round];
      checks++;
      if (bus1.rk_valid !== 1'b1 || bus1.rk_data !== exp_data || bus1.rk_round !== 4'(exp_round) ||
          bus1.rk_last !== (n == 15))
        begin errors++; $display("FAIL stream dec=%b n=%0d: v=%b data=%h round=%0d last=%b, need 1 %h %0d %b",
                                 dec, n, bus1.rk_valid, bus1.rk_data, bus1.rk_round, bus1.rk_last,
                                 exp_data, exp_round, (n == 15)); end
      bus1.rk_ready = ($urandom_range(99) >= 32'(stall_pct));
      held    = bus1.rk_valid && !bus1.rk_ready;
      h_data  = bus1.rk_data;
      h_round = bus1.rk_round;
      h_last  = bus1.rk_last;
      if (bus1.rk_valid === 1'b1 && bus1.rk_ready) n++;
      @(posedge clk); #1;
      cyc++;
    end
    bus1.rk_ready = 1'b0;
    checks++;
    if (n != 16)
      begin errors++; $display("FAIL stream_count dec=%b: transfers=%0d need 16", dec, n); end
    checks++;
    if (bus1.rk_valid !== 1'b0 || bus1.key_ready !== 1'b1)
      begin errors++; $display("FAIL stream_end dec=%b: valid=%b ready=%b, need 0 1",
                               dec, bus1.rk_valid, bus1.key_ready); end
  endtask

  task automatic test_3des(input logic dec);
    int s, b, idx, rnd;
    logic kdir;
    logic [47:0] exp_data;
    bus3.key_in = {K3_TAB[2], K3_TAB[1], K3_TAB[0]};
    bus3.mode_dec = dec; bus3.key_valid = 1'b1; bus3.rk_ready = 1'b1;
    @(posedge clk); #1;
    bus3.key_valid = 1'b0;
    for (int n = 0; n < 48; n++) begin
      s    = n / 16;
      b    = n % 16;
      idx  = dec ? 2 - s : s;
      kdir = dec ? (s != 1) : (s == 1);
      rnd  = kdir ? 15 - b : b;
      exp_data = ref_subkey(K3_TAB[idx], rnd + 1);
      checks++;
      if (bus3.rk_valid !== 1'b1 || bus3.rk_data !== exp_data || bus3.rk_round !== 4'(rnd) ||
          bus3.rk_key_idx !== 2'(idx) || bus3.rk_last !== (n == 47))
        begin errors++; $display("FAIL tdes dec=%b beat%0d: v=%b data=%h round=%0d idx=%0d last=%b, need 1 %h %0d %0d %b",
                                 dec, n, bus3.rk_valid, bus3.rk_data, bus3.rk_round,
                                 bus3.rk_key_idx, bus3.rk_last, exp_data, rnd, idx, (n == 47)); end
      @(posedge clk); #1;
    end
    bus3.rk_ready = 1'b0;
    checks++;
    if (bus3.rk_valid !== 1'b0 || bus3.key_ready !== 1'b1)
      begin errors++; $display("FAIL tdes_end dec=%b: valid=%b ready=%b, need 0 1",
                               dec, bus3.rk_valid, bus3.key_ready); end
  endtask

  task automatic test_abort_reset;
    bus1.key_in = KEY_A; bus1.mode_dec = 1'b0; bus1.key_valid = 1'b1; bus1.rk_ready = 1'b1;
    @(posedge clk); #1;
    bus1.key_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (bus1.rk_valid !== 1'b1 || bus1.rk_data !== K_TAB[6])
      begin errors++; $display("FAIL abort_pre: v=%b data=%h, need 1 %h",
                               bus1.rk_valid, bus1.rk_data, K_TAB[6]); end
    bus1.abort = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus1.rk_valid !== 1'b0 || bus1.key_ready !== 1'b1 || bus1.busy !== 1'b0)
      begin errors++; $display("FAIL abort_flush: v=%b ready=%b busy=%b, need 0 1 0",
                               bus1.rk_valid, bus1.key_ready, bus1.busy); end
    bus1.key_valid = 1'b1;
    @(posedge clk); #1;
    bus1.abort = 1'b0;
    checks++;
    if (bus1.rk_valid !== 1'b0 || bus1.key_ready !== 1'b1)
      begin errors++; $display("FAIL abort_vs_load: v=%b ready=%b, need 0 1",
                               bus1.rk_valid, bus1.key_ready); end
    @(posedge clk); #1;
    bus1.key_valid = 1'b0;
    checks++;
    if (bus1.rk_valid !== 1'b1 || bus1.rk_data !== K_TAB[0] || bus1.rk_round !== 4'd0)
      begin errors++; $display("FAIL restart_k1: v=%b data=%h round=%0d, need 1 %h 0",
                               bus1.rk_valid, bus1.rk_data, bus1.rk_round, K_TAB[0]); end
    @(posedge clk); #1;
    checks++;
    if (bus1.rk_data !== K_TAB[1] || bus1.rk_round !== 4'd1)
      begin errors++; $display("FAIL restart_k2: data=%h round=%0d, need %h 1",
                               bus1.rk_data, bus1.rk_round, K_TAB[1]); end
    rst = 1'b1; bus1.key_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus1.key_valid = 1'b0;
    checks++;
    if (bus1.rk_valid !== 1'b0 || bus1.key_ready !== 1'b1 || bus1.busy !== 1'b0 ||
        bus1.rk_data !== 48'd0 || bus1.rk_round !== 4'd0 || bus1.rk_key_idx !== 2'd0 ||
        bus1.rk_last !== 1'b0)
      begin errors++; $display("FAIL rst_midstream: v=%b ready=%b busy=%b data=%h round=%0d, need 0 1 0 0 0",
                               bus1.rk_valid, bus1.key_ready, bus1.busy, bus1.rk_data, bus1.rk_round); end
    bus1.rk_ready = 1'b0;
  endtask

  initial begin
    bus1.key_valid = 1'b0; bus1.key_in = '0; bus1.mode_dec = 1'b0; bus1.abort = 1'b0; bus1.rk_ready = 1'b0;
    bus3.key_valid = 1'b0; bus3.key_in = '0; bus3.mode_dec = 1'b0; bus3.abort = 1'b0; bus3.rk_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_encrypt();
    test_stream(1'b1, 0);
    test_stream(1'b0, 50);
    test_stream(1'b1, 50);
    test_3des(1'b0);
    test_3des(1'b1);
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
